vga_plot_arbiter: RTL
=====================

// Module: vga_plot_arbiter
// PURPOSE
//   Shares the single VGA adapter write port (x/y/colour/plot) between four pixel
//   producers: erase sweep, game-over/start screen painter, object draw engine, HUD.
//   It grants whole bursts, so a requester owns the port from its first pixel to its last.
//   It replaces the ad-hoc state-select mux ahead of vga_adapter.
//   It sits between the draw/erase/screen generators and vga_adapter.
// PARAMETERS
//   XW        8     x coordinate width (160x120 mode)
//   YW        7     y coordinate width
//   CW        3     colour width
//   TIMEOUT   1023  idle cycles allowed to an owner before forced release (must be >= 1)
//   TOW       10    timeout counter width; must satisfy 2**TOW > TIMEOUT
// PORTS
//   clk         in   1      system clock (CLOCK_50 domain)
//   resetn      in   1      synchronous active-low reset
//   req         in   4      per-requester burst request; bit0 = erase, 1 = screen, 2 = draw, 3 = HUD
//   plot_in     in   4      per-requester pixel-valid strobe
//   last_in     in   4      per-requester final-pixel flag; qualified by plot_in
//   x_in        in   4*XW   packed; requester i at [XW*i +: XW]
//   y_in        in   4*YW   packed; requester i at [YW*i +: YW]
//   colour_in   in   4*CW   packed; requester i at [CW*i +: CW]
//   gnt         out  4      registered one-hot grant; all-zero when idle
//   vga_x       out  XW     registered pixel x to vga_adapter
//   vga_y       out  YW     registered pixel y
//   vga_colour  out  CW     registered pixel colour
//   vga_plot    out  1      registered write strobe
//   busy        out  1      high while a grant is held
//   timeout_err out  1      one-cycle pulse when a grant is forcibly revoked
// BEHAVIOUR
//   - Reset: all outputs 0, state IDLE, timeout counter 0, RR pointer 0 (if enabled).
//     Reset mid-burst drops the burst and emits no pixel.
//   - FSM has two states, IDLE and OWN.
//   - IDLE, req != 0: pick winner w, go to OWN, gnt = 1<<w on the next edge (grant latency 1).
//   - IDLE, req == 0: stay in IDLE.
//   - OWN: on each edge, vga_x/y/colour/plot <= owner's x_in/y_in/colour_in/plot_in.
//     Pixel latency is 1 cycle. Non-owner plot_in is ignored and never appears on vga_plot.
//   - In IDLE, and on the cycle after a release, vga_plot = 0. vga_x/y/colour hold their last value.
//   - Release, owner plot_in & last_in: that pixel is forwarded. gnt clears next edge; go to IDLE.
//   - Release, owner req low: gnt clears next edge; go to IDLE.
//     If plot_in is also high that cycle, the pixel is still forwarded.
//   - Minimum one IDLE cycle between bursts: no back-to-back grants, even to a different requester.
//   - Timeout: counter clears on grant and on every owner plot_in, else increments.
//     Counter == TIMEOUT -> release as above, timeout_err = 1 for one cycle.
//     Counter never wraps.
//   - Simultaneous last_in and timeout on the same cycle: last_in wins, pixel forwarded, no timeout_err.
//   - Request changes while in OWN do not preempt the owner. Arbitration happens only in IDLE.
//   - busy == (state == OWN); gnt != 0 exactly when busy.
// CONFIGURATION
//   PLOT_ARB_RR_EN defined:
//     Round-robin arbitration. A 2-bit pointer p is set to (owner+1) mod 4 on every release.
//     Winner = first set req bit scanning p, p+1, ... mod 4.
//   PLOT_ARB_RR_EN undefined:
//     Fixed priority; the lowest set req index wins (erase highest). No pointer register.
// TESTING
//   1. req=4'b0100, draw plots 3 px (x=10,11,12; y=5; col=3'b010), last on 3rd
//      -> gnt=4'b0100 one cycle after req; vga_plot high 3 cycles, 1 cycle after each plot_in; gnt=0 after last.
//   2. req=4'b1101 together, fixed priority, each burst 1 px with last
//      -> grant order 0,2,3, with exactly one IDLE cycle between grants.
//   3. Same stimulus as 2 with PLOT_ARB_RR_EN, after a prior grant to req 0
//      -> grant order 2,3,0.
//   4. Grant req1, hold req, never plot, TIMEOUT=1023
//      -> timeout_err pulses exactly once, TIMEOUT cycles after grant; gnt=0 and busy=0 next cycle.
//   5. Owner req2 mid-burst while req0 asserts plot_in=1 with x=99
//      -> vga_x never 99, vga_plot tracks req2 only, no preemption.
//   6. resetn=0 for 1 cycle mid-burst -> next cycle all outputs 0, state IDLE; re-grant one cycle after resetn=1.

Source files
------------

// File: rtl/vga_plot_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vga_plot_arbiter
// Function : Burst-granting arbiter that shares the vga_adapter write port among
//            the erase, screen, draw and HUD pixel producers. Define
//            PLOT_ARB_RR_EN for round-robin arbitration (default: fixed priority).
// Revision : 1.0 - initial release
// ============================================================================
module vga_plot_arbiter #(
    parameter int XW      = 8,
    parameter int YW      = 7,
    parameter int CW      = 3,
    parameter int TIMEOUT = 1023,
    parameter int TOW     = 10
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [3:0]      req,
    input  logic [3:0]      plot_in,
    input  logic [3:0]      last_in,
    input  logic [4*XW-1:0] x_in,
    input  logic [4*YW-1:0] y_in,
    input  logic [4*CW-1:0] colour_in,
    output logic [3:0]      gnt,
    output logic [XW-1:0]   vga_x,
    output logic [YW-1:0]   vga_y,
    output logic [CW-1:0]   vga_colour,
    output logic            vga_plot,
    output logic            busy,
    output logic            timeout_err
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    localparam logic [TOW-1:0] c_TIMEOUT = TOW'(TIMEOUT);

    state_t         r_state;
    state_t         w_stateNext;
    logic [1:0]     r_owner;
    logic [1:0]     w_ownerNext;
    logic [TOW-1:0] r_idleCnt;
    logic [TOW-1:0] w_idleCntNext;
    logic [TOW-1:0] w_idleInc;
    logic [1:0]     w_base;
    logic [1:0]     w_winner;
    logic [3:0]     w_gntNext;
    logic           w_plotNext;
    logic           w_tmoNext;
    logic           w_loadPix;
    logic           w_ownPlot;
    logic           w_ownLast;
    logic           w_ownReq;
    logic           w_doneNormal;
    logic           w_timeoutHit;
    logic           w_release;

    logic [XW-1:0]  w_xArr [4];
    logic [YW-1:0]  w_yArr [4];
    logic [CW-1:0]  w_cArr [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_unpack
        assign w_xArr[gi] = x_in[XW*gi +: XW];
        assign w_yArr[gi] = y_in[YW*gi +: YW];
        assign w_cArr[gi] = colour_in[CW*gi +: CW];
    end

`ifdef PLOT_ARB_RR_EN
    logic [1:0] r_ptr;
    logic [1:0] w_ptrNext;
    assign w_base = r_ptr;
`else
    assign w_base = 2'd0;
`endif

    // Scan downward so the requester closest to the base index wins.
    always_comb begin
        w_winner = w_base;
        for (int k = 3; k >= 0; k--) begin
            if (req[w_base + 2'(k)]) begin
                w_winner = w_base + 2'(k);
            end
        end
    end

    assign w_ownPlot    = plot_in[r_owner];
    assign w_ownLast    = last_in[r_owner];
    assign w_ownReq     = req[r_owner];
    assign w_idleInc    = (r_idleCnt == c_TIMEOUT) ? r_idleCnt : r_idleCnt + TOW'(1);
    assign w_timeoutHit = !w_ownPlot && (w_idleInc == c_TIMEOUT);
    assign w_doneNormal = (w_ownPlot && w_ownLast) || !w_ownReq;
    assign w_release    = w_doneNormal || w_timeoutHit;

    always_comb begin
        w_stateNext   = r_state;
        w_gntNext     = gnt;
        w_ownerNext   = r_owner;
        w_idleCntNext = r_idleCnt;
        w_plotNext    = 1'b0;
        w_tmoNext     = 1'b0;
        w_loadPix     = 1'b0;
`ifdef PLOT_ARB_RR_EN
        w_ptrNext     = r_ptr;
`endif
        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_stateNext   = OWN;
                    w_gntNext     = 4'b0001 << w_winner;
                    w_ownerNext   = w_winner;
                    w_idleCntNext = '0;
                end
            end
            OWN: begin
                w_loadPix     = 1'b1;
                w_plotNext    = w_ownPlot;
                w_idleCntNext = w_ownPlot ? '0 : w_idleInc;
                if (w_release) begin
                    // A proper finish (last pixel or request drop) outranks the timeout.
                    w_stateNext   = IDLE;
                    w_gntNext     = 4'b0000;
                    w_idleCntNext = '0;
                    w_tmoNext     = !w_doneNormal;
`ifdef PLOT_ARB_RR_EN
                    w_ptrNext     = r_owner + 2'd1;
`endif
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_owner     <= 2'd0;
            r_idleCnt   <= '0;
            gnt         <= 4'b0000;
            vga_x       <= '0;
            vga_y       <= '0;
            vga_colour  <= '0;
            vga_plot    <= 1'b0;
            timeout_err <= 1'b0;
`ifdef PLOT_ARB_RR_EN
            r_ptr       <= 2'd0;
`endif
        end else begin
            r_state     <= w_stateNext;
            r_owner     <= w_ownerNext;
            r_idleCnt   <= w_idleCntNext;
            gnt         <= w_gntNext;
            vga_plot    <= w_plotNext;
            timeout_err <= w_tmoNext;
`ifdef PLOT_ARB_RR_EN
            r_ptr       <= w_ptrNext;
`endif
            if (w_loadPix) begin
                vga_x      <= w_xArr[r_owner];
                vga_y      <= w_yArr[r_owner];
                vga_colour <= w_cArr[r_owner];
            end
        end
    end

    assign busy = (r_state == OWN);

endmodule
`default_nettype wire
